// File: rtl/counter_pkg.sv
// Shared definitions for bounded counters: run-time mode encodings and the
// load clamp helper reused wherever a loaded value must respect a terminal count.
package counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Limit a requested load value to the terminal count.
    function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] max);
        logic [31:0] res_s;
        if (val > max) begin
            res_s = max;
        end else begin
            res_s = val;
        end
        return res_s;
    endfunction

endpackage

// File: rtl/updown_counter_edge_detect.sv
// Request qualifier: rising-edge pulse (EDGE_MODE=1) or level pass-through (EDGE_MODE=0).
// History reloads the live level during reset so a held input never counts on release.
module edge_detect #(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic clk_N,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic d_q_r;

    // History register, updated on every falling edge including reset.
    always_ff @(negedge clk_N) begin
        d_q_r <= d;
    end

    // The unused history bit in level mode is harmless.
    if (EDGE_MODE) begin : g_edge
        assign pulse = d & ~d_q_r & rst;
    end else begin : g_level
        logic unused_s;
        assign unused_s = d_q_r;
        assign pulse    = d & rst;
    end

endmodule

// File: rtl/updown_counter.sv
// Bounded up/down counter with load, run-time wrap/saturate selection,
// optional edge-qualified requests and registered overflow/underflow pulses.
module updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int MAX       = 2**WIDTH-1,
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic             clk_N,
    input  logic             rst,
    input  logic             add,
    input  logic             sub,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat,
    output logic [WIDTH-1:0] counter,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

    logic             inc_s;
    logic             dec_s;
    logic [WIDTH-1:0] counter_r;
    logic             ovf_r;
    logic             unf_r;
    logic [WIDTH-1:0] cnt_nxt_s;
    logic             ovf_nxt_s;
    logic             unf_nxt_s;

    edge_detect #(.EDGE_MODE(EDGE_MODE)) u_add_edge (
        .clk_N (clk_N),
        .rst   (rst),
        .d     (add),
        .pulse (inc_s)
    );

    edge_detect #(.EDGE_MODE(EDGE_MODE)) u_sub_edge (
        .clk_N (clk_N),
        .rst   (rst),
        .d     (sub),
        .pulse (dec_s)
    );

    // Next-state selection in priority order: load, both, inc, dec, hold.
    always_comb begin
        cnt_nxt_s = counter_r;
        ovf_nxt_s = 1'b0;
        unf_nxt_s = 1'b0;
        if (load) begin
            cnt_nxt_s = WIDTH'(clamp_load(32'(load_val), 32'(MAX)));
        end else begin
            case ({inc_s, dec_s})
                2'b11: cnt_nxt_s = counter_r;
                2'b10: begin
                    if (counter_r < MAX_C) begin
                        cnt_nxt_s = counter_r + ONE_C;
                    end else begin
                        ovf_nxt_s = 1'b1;
                        cnt_nxt_s = (sat == MODE_SAT) ? counter_r : ZERO_C;
                    end
                end
                2'b01: begin
                    if (counter_r > ZERO_C) begin
                        cnt_nxt_s = counter_r - ONE_C;
                    end else begin
                        unf_nxt_s = 1'b1;
                        cnt_nxt_s = (sat == MODE_SAT) ? counter_r : MAX_C;
                    end
                end
                default: cnt_nxt_s = counter_r;
            endcase
        end
    end

    // Count and event registers with synchronous active-low reset.
    always_ff @(negedge clk_N) begin
        if (!rst) begin
            counter_r <= ZERO_C;
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
        end else begin
            counter_r <= cnt_nxt_s;
            ovf_r     <= ovf_nxt_s;
            unf_r     <= unf_nxt_s;
        end
    end

    assign counter = counter_r;
    assign ovf     = ovf_r;
    assign unf     = unf_r;
    assign full    = (counter_r == MAX_C);
    assign empty   = (counter_r == ZERO_C);

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench: edge-mode instance (WIDTH=4, MAX=9) plus a level-mode instance.
module tb_updown_counter;

    logic       clk_N = 1'b1;
    logic       rst   = 1'b0;
    logic       add = 1'b0, sub = 1'b0, load = 1'b0, sat = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] counter;
    logic       full, empty, ovf, unf;

    logic       add_l = 1'b0, sub_l = 1'b0, load_l = 1'b0, sat_l = 1'b0;
    logic [3:0] load_val_l = 4'd0;
    logic [3:0] counter_l;
    logic       full_l, empty_l, ovf_l, unf_l;

    int checks   = 0;
    int failures = 0;

    always #5 clk_N = ~clk_N;

    updown_counter #(.WIDTH(4), .MAX(9), .EDGE_MODE(1'b1)) dut (
        .clk_N(clk_N), .rst(rst), .add(add), .sub(sub), .load(load),
        .load_val(load_val), .sat(sat), .counter(counter), .full(full),
        .empty(empty), .ovf(ovf), .unf(unf)
    );

    updown_counter #(.WIDTH(4), .MAX(9), .EDGE_MODE(1'b0)) dut_lvl (
        .clk_N(clk_N), .rst(rst), .add(add_l), .sub(sub_l), .load(load_l),
        .load_val(load_val_l), .sat(sat_l), .counter(counter_l), .full(full_l),
        .empty(empty_l), .ovf(ovf_l), .unf(unf_l)
    );

    // One falling edge, then settle at the following rising edge before checking.
    task automatic step();
        @(negedge clk_N);
        @(posedge clk_N);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with add held through release.
        add = 1'b1;
        step(); step();
        check("rst_counter", 32'(counter), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b1;
        step();
        check("rel_counter", 32'(counter), 32'd0);
        step(); step(); step();
        check("held_add_counter", 32'(counter), 32'd0);
        check("held_add_empty", 32'(empty), 32'd1);

        // Ten presses in wrap mode.
        add = 1'b0;
        step();
        for (int i = 1; i <= 9; i++) begin
            add = 1'b1; step();
            check($sformatf("press%0d_counter", i), 32'(counter), 32'(i));
            check($sformatf("press%0d_full", i), 32'(full), (i == 9) ? 32'd1 : 32'd0);
            add = 1'b0; step();
        end
        add = 1'b1; step();
        check("wrap_up_counter", 32'(counter), 32'd0);
        check("wrap_up_ovf", 32'(ovf), 32'd1);
        add = 1'b0; step();
        check("wrap_up_ovf_clear", 32'(ovf), 32'd0);

        // Saturate at top.
        load = 1'b1; load_val = 4'd9; step();
        load = 1'b0; sat = 1'b1; step();
        add = 1'b1; step();
        check("sat_up_counter", 32'(counter), 32'd9);
        check("sat_up_ovf", 32'(ovf), 32'd1);
        add = 1'b0; step();
        check("sat_up_ovf_clear", 32'(ovf), 32'd0);
        check("sat_up_hold", 32'(counter), 32'd9);

        // Saturate at bottom.
        load = 1'b1; load_val = 4'd0; step();
        load = 1'b0; step();
        sub = 1'b1; step();
        check("sat_dn_counter", 32'(counter), 32'd0);
        check("sat_dn_unf", 32'(unf), 32'd1);
        sub = 1'b0; step();
        check("sat_dn_unf_clear", 32'(unf), 32'd0);

        // Wrap down.
        sat = 1'b0;
        sub = 1'b1; step();
        check("wrap_dn_counter", 32'(counter), 32'd9);
        check("wrap_dn_unf", 32'(unf), 32'd1);
        check("wrap_dn_full", 32'(full), 32'd1);
        sub = 1'b0; step();
        check("wrap_dn_unf_clear", 32'(unf), 32'd0);

        // Plain decrement.
        sub = 1'b1; step();
        check("dec_counter", 32'(counter), 32'd8);
        sub = 1'b0; step();

        // Clamped load swallows the concurrent add edge.
        load = 1'b1; load_val = 4'd13; add = 1'b1; step();
        check("load_clamp_counter", 32'(counter), 32'd9);
        check("load_clamp_ovf", 32'(ovf), 32'd0);
        load = 1'b0; step();
        check("load_edge_consumed", 32'(counter), 32'd9);
        add = 1'b0;
        load = 1'b1; load_val = 4'd4; step();
        check("load4_counter", 32'(counter), 32'd4);
        load = 1'b0; step();

        // Simultaneous add and sub edges.
        add = 1'b1; sub = 1'b1; step();
        check("both_counter", 32'(counter), 32'd4);
        check("both_ovf", 32'(ovf), 32'd0);
        check("both_unf", 32'(unf), 32'd0);
        add = 1'b0; sub = 1'b0; step();

        // Level mode: add held for five edges from 2.
        load_l = 1'b1; load_val_l = 4'd2; step();
        load_l = 1'b0; add_l = 1'b1; step();
        check("lvl_first", 32'(counter_l), 32'd3);
        step(); step(); step(); step();
        add_l = 1'b0;
        check("lvl_counter", 32'(counter_l), 32'd7);
        step();
        check("lvl_hold", 32'(counter_l), 32'd7);

        // Reset mid-sequence overrides a rising add.
        rst = 1'b0; add = 1'b1; step();
        check("mid_rst_counter", 32'(counter), 32'd0);
        check("mid_rst_lvl_counter", 32'(counter_l), 32'd0);
        rst = 1'b1; step();
        check("mid_rst_release", 32'(counter), 32'd0);
        add = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
